imm_gen_stage: RTL and testbench
================================

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 Parameter: TAGW, default 8, width of the sideband tag carried with each immediate.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers an entry.
REQ-006 in_ready  output  1  stage can accept; registered, a function of occupancy only.
REQ-007 in_instr_31_7  input  25  instruction bits [31:7]; bit k = instr[k+7].
REQ-008 in_immsrc  input  3  immediate format select.
REQ-009 in_tag  input  TAGW  sideband, returned unchanged with its immediate.
REQ-010 flush  input  1  discard all buffered and incoming entries.
REQ-011 out_valid  output  1  head entry is valid.
REQ-012 out_ready  input  1  downstream accepts the head entry.
REQ-013 out_immext  output  XLEN  extended immediate of the head entry.
REQ-014 out_tag  output  TAGW  tag of the head entry.
REQ-015 out_illegal  output  1  head entry used reserved format 3'b111.

Function
REQ-016 Format decode (instr = full instruction word), sign bit s = instr[31]:
- 000 I: sext(instr[31:20]).
- 001 S: sext({instr[31:25], instr[11:7]}).
- 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- 100 U: {instr[31:12], 12'b0}, sign-extended from instr[31] when XLEN=64.
- 101 shamt: zext(instr[24:20]) when XLEN=32; zext(instr[25:20]) when XLEN=64.
- 110 CSR zimm: zext(instr[19:15]).
- 111 reserved: immext zero, illegal flag 1.
REQ-017 Decode is computed at input; the entry stores immext, tag, and illegal flag.
REQ-018 Buffer: 2-entry in-order FIFO; occupancy count 0..2.
REQ-019 Push occurs when in_valid and in_ready and not flush; pop when out_valid and out_ready.
REQ-020 in_ready = (count != 2); does not depend on out_ready combinationally.
REQ-021 out_valid = (count != 0); out_immext, out_tag, and out_illegal come from the head register.
REQ-022 Latency: an entry pushed in cycle N is presented with out_valid=1 in cycle N+1 at the earliest.
REQ-023 Push and pop in the same cycle at count=1 leave count=1, with the new entry at head in the next cycle.
REQ-024 Push and pop in the same cycle at count=0 are impossible, because pop requires out_valid.
REQ-025 Throughput is one entry per cycle sustained while out_ready=1.
REQ-026 Head outputs hold stable while out_valid=1 and out_ready=0.
REQ-027 Flush has priority: count goes to 0 next cycle, the same-cycle input is dropped, and a same-cycle pop is ignored.
REQ-028 When count=0, out_immext and out_tag are driven to zero and out_illegal to 0.
REQ-029 No entry is lost, duplicated, or reordered outside flush.

Reset
REQ-030 reset asserted: count=0, out_valid=0, in_ready=1, and all data registers zero, immediately and without waiting for clk.
REQ-031 Reset deassertion mid-stream: stage resumes accepting on the first rising edge after release; pre-reset entries are never output.

Verification
REQ-032 XLEN=32, instr 0xFFF00093 (instr_31_7 0x1FFE001), immsrc 000, out_ready=1 -> next cycle out_valid=1, out_immext 0xFFFFFFFF.
REQ-033 XLEN=64, instr 0x800000B7, immsrc 100 -> out_immext 0xFFFFFFFF80000000; XLEN=64 slli shamt 33 (instr[25:20]=100001), immsrc 101 -> 0x21; immsrc 110 with instr[19:15]=11111 -> 0x1F.
REQ-034 Backpressure: push tags 1, 2, 3 on consecutive cycles with out_ready=0 -> in_ready=0 after two pushes; tag 3 is held upstream; then out_ready=1 drains tags 1, 2, 3 in order with no gaps.
REQ-035 Flush at count=2 with in_valid=1 and tag 9 -> next cycle count=0 and out_valid=0; tag 9 never appears on out_tag.
REQ-036 immsrc 111 -> out_illegal=1 and out_immext 0; a following immsrc 000 entry -> out_illegal=0.
REQ-037 reset pulsed between clock edges with count=2 -> out_valid=0 and in_ready=1 before the next edge.

Source files
------------

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decodes instruction immediates into a 2-entry in-order FIFO carrying tag and illegal flag
module imm_gen_stage #(
  parameter int XLEN = 32,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     in_instr_31_7,
  input  logic [2:0]      in_immsrc,
  input  logic [TAGW-1:0] in_tag,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_immext,
  output logic [TAGW-1:0] out_tag,
  output logic            out_illegal
);
  localparam int W = XLEN + TAGW + 1;
  logic [31:7] ins;
  logic [XLEN-1:0] imm;
  logic [W-1:0] ent, head, tail;
  logic [1:0] count;
  logic push, pop;
  assign ins = in_instr_31_7;
  always_comb begin
    imm = in_immsrc == 3'd0 ? XLEN'($signed(ins[31:20])) :
          in_immsrc == 3'd1 ? XLEN'($signed({ins[31:25], ins[11:7]})) :
          in_immsrc == 3'd2 ? XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})) :
          in_immsrc == 3'd3 ? XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})) :
          in_immsrc == 3'd4 ? XLEN'($signed({ins[31:12], 12'b0})) :
          in_immsrc == 3'd5 ? (XLEN == 64 ? XLEN'(ins[25:20]) : XLEN'(ins[24:20])) :
          in_immsrc == 3'd6 ? XLEN'(ins[19:15]) : '0;
  end
  assign ent = {imm, in_tag, in_immsrc == 3'd7};
  assign in_ready = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready;
  assign {out_immext, out_tag, out_illegal} = out_valid ? head : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop || count == 2'd0) head <= count == 2'd2 ? tail : ent;
      if (push && (count == 2'd2) == pop) tail <= ent;
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: table, directed and randomized checks of imm_gen_stage at XLEN 32 and 64
module tb_imm_gen_stage;
  logic clk = 0, reset = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [24:0] in_instr_31_7 = '0;
  logic [2:0] in_immsrc = '0;
  logic [7:0] in_tag = '0;
  logic rdy32, rdy64, v32, v64, il32, il64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [7:0] tag32, tag64;
  int passed = 0, total = 0;
  localparam longint P31 = 64'sd2147483648;
  localparam longint P32 = 64'sd4294967296;
  typedef struct {logic [31:0] ins; logic [2:0] src; logic [63:0] e32; logic [63:0] e64; logic ill;} vec_t;
  typedef struct {logic [63:0] e32; logic [63:0] e64; logic [7:0] tag; logic ill;} ent_t;
  vec_t tbl[10];
  ent_t q[$];
  ent_t e;
  always #5 clk = ~clk;
  imm_gen_stage #(.XLEN(32), .TAGW(8)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr_31_7(in_instr_31_7), .in_immsrc(in_immsrc), .in_tag(in_tag), .flush(flush),
    .out_valid(v32), .out_ready(out_ready), .out_immext(imm32), .out_tag(tag32), .out_illegal(il32));
  imm_gen_stage #(.XLEN(64), .TAGW(8)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr_31_7(in_instr_31_7), .in_immsrc(in_immsrc), .in_tag(in_tag), .flush(flush),
    .out_valid(v64), .out_ready(out_ready), .out_immext(imm64), .out_tag(tag64), .out_illegal(il64));
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a === x) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, x);
  endtask
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input bit x64);
    logic [63:0] u;
    longint v;
    u = {32'b0, ins};
    case (src)
      3'd0: begin v = longint'(u >> 20); if (v >= 2048) v -= 4096; end
      3'd1: begin v = longint'(((u >> 25) & 127) * 32 + ((u >> 7) & 31)); if (v >= 2048) v -= 4096; end
      3'd2: begin
        v = longint'(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2);
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin
        v = longint'(((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2);
        if (v >= 1048576) v -= 2097152;
      end
      3'd4: begin v = longint'(u & 64'hFFFF_F000); if (v >= P31) v -= P32; end
      3'd5: v = longint'((u >> 20) & (x64 ? 64'd63 : 64'd31));
      3'd6: v = longint'((u >> 15) & 31);
      default: v = 0;
    endcase
    return x64 ? 64'(v) : {32'b0, 32'(v)};
  endfunction
  task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tag);
    in_instr_31_7 = ins[31:7];
    in_immsrc = src;
    in_tag = tag;
  endtask
  task automatic chk_out(input string n, input bit v, input ent_t x);
    chk({n, " valid32"}, {63'b0, v32}, {63'b0, v});
    chk({n, " valid64"}, {63'b0, v64}, {63'b0, v});
    chk({n, " imm32"}, {32'b0, imm32}, v ? x.e32 : 64'b0);
    chk({n, " imm64"}, imm64, v ? x.e64 : 64'b0);
    chk({n, " tag"}, {48'b0, tag32, tag64}, v ? {48'b0, x.tag, x.tag} : 64'b0);
    chk({n, " ill"}, {62'b0, il32, il64}, v ? {62'b0, x.ill, x.ill} : 64'b0);
  endtask
  task automatic chk_rdy(input string n, input bit r);
    chk(n, {62'b0, rdy32, rdy64}, {62'b0, r, r});
  endtask
  initial begin
    tbl[0] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[1] = '{32'h800000B7, 3'd4, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    tbl[2] = '{32'h02101013, 3'd5, 64'h1, 64'h21, 1'b0};
    tbl[3] = '{32'h000F8073, 3'd6, 64'h1F, 64'h1F, 1'b0};
    tbl[4] = '{32'hFE000E23, 3'd1, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[5] = '{32'h00000463, 3'd2, 64'h8, 64'h8, 1'b0};
    tbl[6] = '{32'hFFFFF06F, 3'd3, 64'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0};
    tbl[7] = '{32'hFFFFFFFF, 3'd7, 64'h0, 64'h0, 1'b1};
    tbl[8] = '{32'h7FF00093, 3'd0, 64'h7FF, 64'h7FF, 1'b0};
    tbl[9] = '{32'h00001037, 3'd4, 64'h1000, 64'h1000, 1'b0};
    #1 reset = 1;
    #2;
    e = '{64'h0, 64'h0, 8'h0, 1'b0};
    chk_out("reset", 1'b0, e);
    chk_rdy("reset ready", 1'b1);
    repeat (2) @(negedge clk);
    reset = 0;
    out_ready = 1;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].ins, tbl[i].src, 8'(i + 16));
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      e = '{tbl[i].e32, tbl[i].e64, 8'(i + 16), tbl[i].ill};
      chk_out($sformatf("vec%0d", i), 1'b1, e);
    end
    @(negedge clk);
    chk_out("drained", 1'b0, e);
    out_ready = 0;
    drive(32'h00100093, 3'd0, 8'd1);
    in_valid = 1;
    @(negedge clk);
    drive(32'h00200093, 3'd0, 8'd2);
    @(negedge clk);
    drive(32'h00300093, 3'd0, 8'd3);
    chk_rdy("bp full ready", 1'b0);
    out_ready = 1;
    for (int t = 1; t <= 3; t++) begin
      e = '{64'(t), 64'(t), 8'(t), 1'b0};
      chk_out($sformatf("bp drain%0d", t), 1'b1, e);
      @(negedge clk);
      if (t == 2) in_valid = 0;
    end
    chk_out("bp empty", 1'b0, e);
    out_ready = 0;
    drive(32'h00500093, 3'd0, 8'd5);
    in_valid = 1;
    repeat (2) @(negedge clk);
    chk_rdy("flush pre ready", 1'b0);
    drive(32'h00900093, 3'd0, 8'd9);
    flush = 1;
    out_ready = 1;
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    chk_out("flush", 1'b0, e);
    chk_rdy("flush ready", 1'b1);
    @(negedge clk);
    chk_out("flush after", 1'b0, e);
    out_ready = 0;
    drive(32'h00600093, 3'd0, 8'd6);
    in_valid = 1;
    repeat (2) @(negedge clk);
    in_valid = 0;
    chk_rdy("rst pre ready", 1'b0);
    #1 reset = 1;
    #1;
    chk_out("async reset", 1'b0, e);
    chk_rdy("async reset ready", 1'b1);
    #1 reset = 0;
    @(negedge clk);
    drive(32'h04400093, 3'd0, 8'h44);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    e = '{64'h44, 64'h44, 8'h44, 1'b0};
    chk_out("post reset", 1'b1, e);
    flush = 1;
    @(negedge clk);
    flush = 0;
    for (int c = 0; c < 500; c++) begin
      logic [31:0] ins;
      logic [2:0] src;
      logic [7:0] tag;
      bit v, r, f, pu, po;
      @(negedge clk);
      e = q.size() != 0 ? q[0] : '{64'h0, 64'h0, 8'h0, 1'b0};
      chk_out("rand", q.size() != 0, e);
      chk_rdy("rand ready", q.size() < 2);
      ins = $urandom;
      src = 3'($urandom_range(0, 7));
      tag = 8'($urandom);
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) != 0;
      f = $urandom_range(0, 15) == 0;
      drive(ins, src, tag);
      in_valid = v;
      out_ready = r;
      flush = f;
      pu = v && q.size() < 2 && !f;
      po = r && q.size() != 0;
      if (f) q.delete();
      else begin
        if (po) void'(q.pop_front());
        if (pu) q.push_back('{ref_imm(ins, src, 1'b0), ref_imm(ins, src, 1'b1), tag, src == 3'd7});
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
